// File: rtl/bus_arb4.sv
`default_nettype none
// ============================================================================
// Module      : bus_arb4
// Description : Four-requester round-robin bus arbiter with hold timeout and
//               a one-cycle turnaround between tenures.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arb4 #(
    parameter logic [7:0] HOLD_MAX = 8'd15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] owner,
    output logic       busy,
    output logic       timeout
);

    localparam logic [7:0] c_HC_SAT = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_ptr, w_ptr_nxt;
    logic [7:0] r_hc, w_hc_nxt;
    logic [3:0] r_gnt, w_gnt_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_timeout, w_timeout_nxt;
    logic [1:0] w_winner;
    logic [1:0] w_idx;

    // Scan downward so the last hit is the nearest index above the pointer.
    always_comb begin
        w_winner = r_ptr;
        w_idx    = r_ptr;
        for (int i = 4; i >= 1; i--) begin
            w_idx = r_ptr + 2'(i);
            if (req[w_idx]) begin
                w_winner = w_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= 2'd3;
            r_hc      <= 8'd0;
            r_gnt     <= 4'b0000;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_hc      <= w_hc_nxt;
            r_gnt     <= w_gnt_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_hc_nxt      = r_hc;
        w_gnt_nxt     = 4'b0000;
        w_busy_nxt    = 1'b0;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en && (req != 4'b0000)) begin
                    w_state_nxt = ST_GRANT;
                    w_ptr_nxt   = w_winner;
                    w_hc_nxt    = 8'd1;
                    w_gnt_nxt   = 4'b0001 << w_winner;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_GRANT: begin
                // A same-edge drop wins over the timeout, so it is tested first.
                if (!req[r_ptr]) begin
                    w_state_nxt = ST_RELEASE;
                end else if ((HOLD_MAX != 8'd0) && (r_hc == HOLD_MAX)) begin
                    w_state_nxt   = ST_RELEASE;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_gnt_nxt  = r_gnt;
                    w_busy_nxt = 1'b1;
                    if (r_hc != c_HC_SAT) begin
                        w_hc_nxt = r_hc + 8'd1;
                    end
                end
            end
            ST_RELEASE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign gnt     = r_gnt;
    assign owner   = r_ptr;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_bus_arb4.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arb4
// Description : Directed self-checking bench for bus_arb4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arb4;

    logic       clk;
    logic       rst;
    logic       en, en0;
    logic [3:0] req, req0;
    logic [3:0] gnt, gnt0;
    logic [1:0] owner, owner0;
    logic       busy, busy0;
    logic       timeout, timeout0;

    int vectors;
    int miscompares;

    bus_arb4 #(.HOLD_MAX(8'd15)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(gnt), .owner(owner), .busy(busy), .timeout(timeout)
    );

    bus_arb4 #(.HOLD_MAX(8'd0)) dut0 (
        .clk(clk), .rst(rst), .en(en0), .req(req0),
        .gnt(gnt0), .owner(owner0), .busy(busy0), .timeout(timeout0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        req = 4'b0000;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b0; req = 4'b0000; en0 = 1'b0; req0 = 4'b0000;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0 || owner !== 2'd3) begin
            miscompares++;
            $display("FAIL reset_outputs: got gnt=%b busy=%b to=%b owner=%0d, want 0000 0 0 3",
                     gnt, busy, timeout, owner);
        end
        vectors++;
        if (dut.r_hc !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_hc: got %0d, want 0", dut.r_hc);
        end
        step();
        rst = 1'b0;
    endtask

    // Full rotation under a constant 1111 request with timeouts.
    task automatic test_rotation();
        logic [3:0] exp;
        en = 1'b1; req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp = 4'b0001 << (k % 4);
            step();
            vectors++;
            if (gnt !== exp || busy !== 1'b1 || owner !== 2'(k % 4)) begin
                miscompares++;
                $display("FAIL rot_grant%0d: got gnt=%b busy=%b owner=%0d, want %b 1 %0d",
                         k, gnt, busy, owner, exp, k % 4);
            end
            if (k == 4) break;
            for (int c = 2; c <= 15; c++) begin
                step();
                vectors++;
                if (gnt !== exp || timeout !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rot_hold%0d_c%0d: got gnt=%b to=%b, want %b 0",
                             k, c, gnt, timeout, exp);
                end
            end
            step();
            vectors++;
            if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b1) begin
                miscompares++;
                $display("FAIL rot_timeout%0d: got gnt=%b busy=%b to=%b, want 0000 0 1",
                         k, gnt, busy, timeout);
            end
            step();
            vectors++;
            if (gnt !== 4'b0000 || timeout !== 1'b0) begin
                miscompares++;
                $display("FAIL rot_idle%0d: got gnt=%b to=%b, want 0000 0", k, gnt, timeout);
            end
        end
        req = 4'b0000;
        step();
        vectors++;
        if (gnt !== 4'b0000 || timeout !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rot_drop: got gnt=%b busy=%b to=%b, want 0000 0 0", gnt, busy, timeout);
        end
        step();
    endtask

    task automatic test_single_pulse();
        req = 4'b0100;
        step();
        vectors++;
        if (gnt !== 4'b0100 || owner !== 2'd2) begin
            miscompares++;
            $display("FAIL pulse_grant: got gnt=%b owner=%0d, want 0100 2", gnt, owner);
        end
        req = 4'b0000;
        step();
        vectors++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL pulse_release: got gnt=%b busy=%b to=%b, want 0000 0 0", gnt, busy, timeout);
        end
        step();
        vectors++;
        if (gnt !== 4'b0000 || timeout !== 1'b0 || owner !== 2'd2) begin
            miscompares++;
            $display("FAIL pulse_idle: got gnt=%b to=%b owner=%0d, want 0000 0 2", gnt, timeout, owner);
        end
    endtask

    // Owner 1 drops its request on exactly the edge where HC reaches the limit.
    task automatic test_same_edge();
        req = 4'b0010;
        step();
        vectors++;
        if (gnt !== 4'b0010) begin
            miscompares++;
            $display("FAIL same_grant: got gnt=%b, want 0010", gnt);
        end
        for (int c = 2; c <= 15; c++) step();
        vectors++;
        if (gnt !== 4'b0010 || dut.r_hc !== 8'd15) begin
            miscompares++;
            $display("FAIL same_hold: got gnt=%b hc=%0d, want 0010 15", gnt, dut.r_hc);
        end
        req = 4'b0000;
        step();
        vectors++;
        if (gnt !== 4'b0000 || timeout !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL same_release: got gnt=%b busy=%b to=%b, want 0000 0 0", gnt, busy, timeout);
        end
        step();
    endtask

    task automatic test_enable();
        do_reset();
        en = 1'b0; req = 4'b1010;
        for (int c = 0; c < 6; c++) begin
            step();
            vectors++;
            if (gnt !== 4'b0000) begin
                miscompares++;
                $display("FAIL en_block%0d: got gnt=%b, want 0000", c, gnt);
            end
        end
        en = 1'b1;
        step();
        vectors++;
        if (gnt !== 4'b0010 || owner !== 2'd1) begin
            miscompares++;
            $display("FAIL en_grant: got gnt=%b owner=%0d, want 0010 1", gnt, owner);
        end
        en = 1'b0; req = 4'b1110;
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if (gnt !== 4'b0010 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL en_hold%0d: got gnt=%b busy=%b, want 0010 1", c, gnt, busy);
            end
        end
        req = 4'b1100;
        step();
        vectors++;
        if (gnt !== 4'b0000 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL en_release: got gnt=%b to=%b, want 0000 0", gnt, timeout);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1'b1; req = 4'b1000;
        step();
        vectors++;
        if (gnt !== 4'b1000) begin
            miscompares++;
            $display("FAIL mid_grant: got gnt=%b, want 1000", gnt);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0 || owner !== 2'd3) begin
            miscompares++;
            $display("FAIL mid_async: got gnt=%b busy=%b to=%b owner=%0d, want 0000 0 0 3",
                     gnt, busy, timeout, owner);
        end
        step();
        req = 4'b1001;
        rst = 1'b0;
        #1;
        vectors++;
        if (gnt !== 4'b0000 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_no_early: got gnt=%b to=%b, want 0000 0", gnt, timeout);
        end
        step();
        vectors++;
        if (gnt !== 4'b0001 || owner !== 2'd0) begin
            miscompares++;
            $display("FAIL mid_next: got gnt=%b owner=%0d, want 0001 0", gnt, owner);
        end
        req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_hold_zero();
        en0 = 1'b1; req0 = 4'b0001;
        for (int c = 0; c < 300; c++) begin
            step();
            vectors++;
            if (gnt0 !== 4'b0001 || timeout0 !== 1'b0 || busy0 !== 1'b1) begin
                miscompares++;
                $display("FAIL hz_cycle%0d: got gnt=%b busy=%b to=%b, want 0001 1 0",
                         c, gnt0, busy0, timeout0);
            end
        end
        vectors++;
        if (dut0.r_hc !== 8'd255) begin
            miscompares++;
            $display("FAIL hz_hc_sat: got %0d, want 255", dut0.r_hc);
        end
        req0 = 4'b0000;
        step();
        vectors++;
        if (gnt0 !== 4'b0000 || timeout0 !== 1'b0) begin
            miscompares++;
            $display("FAIL hz_release: got gnt=%b to=%b, want 0000 0", gnt0, timeout0);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_rotation();
        test_single_pulse();
        test_same_edge();
        test_enable();
        test_reset_mid();
        test_hold_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
